// File: rtl/fft_frame_sequencer.sv
// Frame sequencer around a combinational FFT: fills a frame, waits for settle, drains bins.
// Optional macro FFT_SEQ_FRAME_COUNT_EN adds a 16-bit completed-frame counter.
module fft_frame_sequencer #(
   parameter int BUFFER_SIZE   = 8,
   parameter int SAMPLE_SIZE   = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [SAMPLE_SIZE-1:0]             in_sample,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] fft_in_real,
   input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] fft_out_real,
   input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] fft_out_imag,
   output logic [SAMPLE_SIZE-1:0]             out_real,
   output logic [SAMPLE_SIZE-1:0]             out_imag,
   output logic [$clog2(BUFFER_SIZE)-1:0]     out_index,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               out_last,
`ifdef FFT_SEQ_FRAME_COUNT_EN
   output logic [15:0]                        frame_count,
`endif
   output logic                               busy
);

   localparam int IW = $clog2(BUFFER_SIZE);
   localparam int FW = BUFFER_SIZE * SAMPLE_SIZE;
   localparam int CW = $clog2(SETTLE_CYCLES) + 1;

   localparam logic [1:0] FILL   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;

   localparam logic [IW-1:0] LAST_IDX   = IW'(BUFFER_SIZE - 1);
   localparam logic [CW-1:0] LAST_SETTLE = CW'(SETTLE_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [FW-1:0] res_re_q, res_re_d;
   logic [FW-1:0] res_im_q, res_im_d;
`ifdef FFT_SEQ_FRAME_COUNT_EN
   logic [15:0]   fcnt_q, fcnt_d;
`endif

   always_comb begin
      state_d  = state_q;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      cnt_d    = cnt_q;
      frame_d  = frame_q;
      res_re_d = res_re_q;
      res_im_d = res_im_q;
`ifdef FFT_SEQ_FRAME_COUNT_EN
      fcnt_d   = fcnt_q;
`endif
      unique case (state_q)
         FILL: begin
            if (in_valid) begin
               frame_d[wr_idx_q*SAMPLE_SIZE +: SAMPLE_SIZE] = in_sample;
               wr_idx_d = wr_idx_q + IW'(1);
               if (wr_idx_q == LAST_IDX) begin
                  state_d = SETTLE;
                  cnt_d   = '0;
               end
            end
         end
         SETTLE: begin
            // Capture on the last settle edge so the datapath has fully resolved
            if (cnt_q == LAST_SETTLE) begin
               res_re_d = fft_out_real;
               res_im_d = fft_out_imag;
               rd_idx_d = '0;
               cnt_d    = '0;
               state_d  = DRAIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DRAIN: begin
            if (out_ready) begin
               rd_idx_d = rd_idx_q + IW'(1);
               if (rd_idx_q == LAST_IDX) begin
                  state_d = FILL;
`ifdef FFT_SEQ_FRAME_COUNT_EN
                  fcnt_d  = fcnt_q + 16'd1;
`endif
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= FILL;
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         cnt_q    <= '0;
         frame_q  <= '0;
         res_re_q <= '0;
         res_im_q <= '0;
`ifdef FFT_SEQ_FRAME_COUNT_EN
         fcnt_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         cnt_q    <= cnt_d;
         frame_q  <= frame_d;
         res_re_q <= res_re_d;
         res_im_q <= res_im_d;
`ifdef FFT_SEQ_FRAME_COUNT_EN
         fcnt_q   <= fcnt_d;
`endif
      end
   end

   logic drain_s;
   assign drain_s     = (state_q == DRAIN);
   assign in_ready    = (state_q == FILL);
   assign busy        = (state_q != FILL);
   assign out_valid   = drain_s;
   assign out_last    = drain_s && (rd_idx_q == LAST_IDX);
   assign out_index   = rd_idx_q;
   assign fft_in_real = frame_q;
   assign out_real    = drain_s ? res_re_q[rd_idx_q*SAMPLE_SIZE +: SAMPLE_SIZE] : '0;
   assign out_imag    = drain_s ? res_im_q[rd_idx_q*SAMPLE_SIZE +: SAMPLE_SIZE] : '0;
`ifdef FFT_SEQ_FRAME_COUNT_EN
   assign frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a loopback FFT stub.
// Covers fill, settle latency, drain, back-pressure, ignored input and mid-drain reset.
module tb_fft_frame_sequencer;

   localparam int N  = 8;
   localparam int S  = 16;
   localparam int SC = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [S-1:0]   in_sample;
   logic           in_valid;
   logic           in_ready;
   logic [N*S-1:0] fft_in_real;
   logic [N*S-1:0] fft_out_real;
   logic [N*S-1:0] fft_out_imag;
   logic [S-1:0]   out_real;
   logic [S-1:0]   out_imag;
   logic [2:0]     out_index;
   logic           out_valid;
   logic           out_ready;
   logic           out_last;
   logic           busy;
`ifdef FFT_SEQ_FRAME_COUNT_EN
   logic [15:0]    frame_count;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [N*S-1:0] exp_frame;

   always #5 clk = ~clk;

   assign fft_out_real = fft_in_real;
   assign fft_out_imag = '0;

   fft_frame_sequencer #(
      .BUFFER_SIZE  (N),
      .SAMPLE_SIZE  (S),
      .SETTLE_CYCLES(SC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_sample   (in_sample),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .fft_in_real (fft_in_real),
      .fft_out_real(fft_out_real),
      .fft_out_imag(fft_out_imag),
      .out_real    (out_real),
      .out_imag    (out_imag),
      .out_index   (out_index),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
`ifdef FFT_SEQ_FRAME_COUNT_EN
      .frame_count (frame_count),
`endif
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [N*S-1:0] got,
                        input logic [N*S-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Streams one frame starting at base; leaves in_valid high with 0x7FFF when junk is set.
   task automatic send_frame(input logic [S-1:0] base, input bit junk);
      for (int i = 0; i < N; i++) begin
         check("fill_in_ready", in_ready, 1);
         in_valid  = 1'b1;
         in_sample = base + S'(i);
         exp_frame[i*S +: S] = base + S'(i);
         @(negedge clk);
      end
      in_valid  = junk;
      in_sample = 16'h7FFF;
      check("settle_in_ready", in_ready, 0);
      check("settle_busy", busy, 1);
      check("settle_valid0", out_valid, 0);
      @(negedge clk);
      check("settle_valid1", out_valid, 0);
      check("settle_frame", fft_in_real, exp_frame);
      @(negedge clk);
      check("first_valid", out_valid, 1);
   endtask

   task automatic drain(input logic [S-1:0] base, input int stall_at,
                        input int stall_n, input int abort_at);
      for (int i = 0; i < N; i++) begin
         if (i == abort_at) begin
            rst = 1'b1;
            #1;
            check("abort_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_real", out_real, 0);
            @(negedge clk);
            rst       = 1'b0;
            out_ready = 1'b0;
            in_valid  = 1'b0;
            check("post_rst_ready", in_ready, 1);
            check("post_rst_index", out_index, 0);
            check("post_rst_frame", fft_in_real, 0);
            return;
         end
         check("bin_valid", out_valid, 1);
         check("bin_real", out_real, base + S'(i));
         check("bin_imag", out_imag, 0);
         check("bin_index", out_index, i);
         check("bin_last", out_last, (i == N - 1));
         check("bin_busy", busy, 1);
         check("bin_in_ready", in_ready, 0);
         if (i == stall_at) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               @(negedge clk);
               check("hold_valid", out_valid, 1);
               check("hold_real", out_real, base + S'(i));
               check("hold_index", out_index, i);
            end
         end
         out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      check("done_in_ready", in_ready, 1);
      check("done_valid", out_valid, 0);
      check("done_busy", busy, 0);
      check("done_last", out_last, 0);
      check("stable_frame", fft_in_real, exp_frame);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sample = '0;
      out_ready = 1'b0;
      exp_frame = '0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_last", out_last, 0);
      check("rst_real", out_real, 0);
      check("rst_imag", out_imag, 0);
      check("rst_index", out_index, 0);
      check("rst_frame", fft_in_real, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rel_in_ready", in_ready, 1);
      check("rel_valid", out_valid, 0);

      send_frame(16'd1, 1'b0);
      drain(16'd1, -1, 0, -1);

      send_frame(16'd1, 1'b1);
      drain(16'd1, 3, 5, -1);

      send_frame(16'h0040, 1'b0);
      drain(16'h0040, -1, 0, -1);
`ifdef FFT_SEQ_FRAME_COUNT_EN
      check("frame_count3", frame_count, 3);
`endif

      send_frame(16'h0020, 1'b0);
      drain(16'h0020, -1, 0, 5);
`ifdef FFT_SEQ_FRAME_COUNT_EN
      check("frame_count_rst", frame_count, 0);
`endif
      send_frame(16'h0030, 1'b0);
      drain(16'h0030, -1, 0, -1);
`ifdef FFT_SEQ_FRAME_COUNT_EN
      check("frame_count1", frame_count, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 The block SHALL have parameter BUFFER_SIZE, default 8: points per FFT frame; a power of two, at least 2.
REQ-002 The block SHALL have parameter SAMPLE_SIZE, default 16: bits per signed sample and per output component.
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 2: clocks allowed for the combinational FFT datapath to settle; at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port in_sample, input, SAMPLE_SIZE bits: signed real time-domain sample.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_sample is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 The block SHALL have port fft_in_real, output, BUFFER_SIZE*SAMPLE_SIZE bits: frame driven to the FFT datapath; sample k occupies bits [k*SAMPLE_SIZE +: SAMPLE_SIZE].
REQ-010 The block SHALL have ports fft_out_real and fft_out_imag, input, BUFFER_SIZE*SAMPLE_SIZE bits each: FFT result, bin k occupying the same slice positions as sample k.
REQ-011 The block SHALL have ports out_real and out_imag, output, SAMPLE_SIZE bits each: the current bin.
REQ-012 The block SHALL have port out_index, output, $clog2(BUFFER_SIZE) bits: the current bin number.
REQ-013 The block SHALL have port out_valid, input-to-consumer output, 1 bit: a bin is presented on out_real, out_imag and out_index.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the presented bin.
REQ-015 The block SHALL have port out_last, output, 1 bit: the presented bin is bin BUFFER_SIZE-1.
REQ-016 The block SHALL have port busy, output, 1 bit: the block is in state SETTLE or DRAIN.

Function
REQ-017 The block SHALL use exactly three states: FILL, SETTLE and DRAIN.
REQ-018 In FILL: in_ready=1; each in_valid&&in_ready edge writes in_sample into slot wr_idx and increments wr_idx.
REQ-019 FILL SHALL go to SETTLE on the edge that accepts slot BUFFER_SIZE-1; wr_idx then wraps to 0.
REQ-020 The frame register SHALL drive fft_in_real directly and SHALL remain stable throughout SETTLE and DRAIN.
REQ-021 SETTLE SHALL count SETTLE_CYCLES edges; on the last one it captures fft_out_real and fft_out_imag into an output register, sets rd_idx=0 and enters DRAIN.
REQ-022 First out_valid SHALL be high exactly SETTLE_CYCLES edges after the edge that accepted the last sample.
REQ-023 In DRAIN: out_valid=1, out_real/out_imag equal slice rd_idx of the captured result, out_index=rd_idx, out_last=(rd_idx==BUFFER_SIZE-1).
REQ-024 Each out_valid&&out_ready edge in DRAIN SHALL increment rd_idx.
REQ-025 While out_ready=0, all DRAIN outputs SHALL hold unchanged.
REQ-026 The handshake on the last bin SHALL return the block to FILL, with in_ready=1 in the next cycle.
REQ-027 in_ready SHALL be 0 in SETTLE and DRAIN; in_valid in those states SHALL be ignored and SHALL NOT be stored.
REQ-028 out_valid SHALL be 0 outside DRAIN; out_ready outside DRAIN SHALL have no effect.
REQ-029 Throughput: one sample per clock in FILL and one bin per clock in DRAIN, with no bubbles between consecutive handshakes.

Reset
REQ-030 While rst=1, asynchronously: state=FILL, wr_idx=0, rd_idx=0, SETTLE counter=0, in_ready=1.
REQ-031 While rst=1, asynchronously: out_valid=0, out_last=0, busy=0, out_real=0, out_imag=0, out_index=0, fft_in_real=0.
REQ-032 A reset in any state SHALL discard the partial frame or undrained result; the first sample after reset is written to slot 0.

Configuration
REQ-033 With macro FFT_SEQ_FRAME_COUNT_EN defined, the block SHALL add output frame_count, 16 bits, reset 0, incremented on each last-bin handshake and wrapping from 65535 to 0.
REQ-034 Without FFT_SEQ_FRAME_COUNT_EN, port frame_count and its logic SHALL be absent; all other behaviour is identical.

Verification
Setup: BUFFER_SIZE=8, SAMPLE_SIZE=16, SETTLE_CYCLES=2. The bench stub loops fft_in_real to fft_out_real and ties fft_out_imag to 0.
REQ-035 The bench SHALL check reset release: in_ready=1, out_valid=0, busy=0, all outputs 0.
REQ-036 Samples 1..8 streamed on consecutive cycles -> in_ready=0 after the 8th; out_valid rises 2 edges later.
REQ-036a Continuing REQ-036 with out_ready=1 -> bins out_real=1..8 in order, out_imag=0, out_index=0..7, out_last only with index 7; in_ready=1 on the next cycle.
REQ-037 out_ready=0 for 5 cycles at bin 3 -> out_real=4 and out_index=3 held stable for all 5 cycles; bin 4 follows the first accept.
REQ-038 in_valid=1 with value 0x7FFF throughout SETTLE and DRAIN -> the next frame contains only values sent after in_ready returns to 1.
REQ-039 rst pulsed at bin 5 of DRAIN -> out_valid=0 immediately; a new frame of 8 samples produces a full 8-bin drain starting at index 0.
REQ-040 With FFT_SEQ_FRAME_COUNT_EN defined, 3 complete frames -> frame_count=3; a preset of 65535 plus one frame -> frame_count=0.
